// File: rtl/character_renderer.sv
// Sprite renderer: per-frame shadowed position/pose, per-pixel hit test, ROM fetch and colour-key.
// Two-cycle latency from pixel_en to pixel_out_en; free-running pipeline with no backpressure.
module character_renderer #(
  parameter int PHY_WIDTH = 10,
  parameter int PIXEL_WIDTH = 12,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CHAR_WIDTH_X = 32,
  parameter int CHAR_WIDTH_Y = 32,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   pixel_en,
  input  logic [9:0]             h_cnt,
  input  logic [9:0]             v_cnt,
  input  logic                   frame_start,
  input  logic [PHY_WIDTH:0]     pos_x,
  input  logic [PHY_WIDTH:0]     pos_y,
  input  logic [1:0]             face,
  input  logic [3:0]             char_state,
  output logic [11:0]            rom_addr,
  input  logic [11:0]            rom_data,
  output logic [PIXEL_WIDTH-1:0] pixel_rgb,
  output logic                   sprite_hit,
  output logic                   pixel_out_en
);

  localparam int CW = $clog2(CHAR_WIDTH_X);
  localparam int RW = $clog2(CHAR_WIDTH_Y);
  localparam logic signed [11:0] X_BASE = 12'(H_RES - CHAR_WIDTH_X);
  localparam logic signed [11:0] Y_BASE = 12'(V_RES - CHAR_WIDTH_Y);
  localparam logic signed [11:0] WX = 12'(CHAR_WIDTH_X);
  localparam logic signed [11:0] WY = 12'(CHAR_WIDTH_Y);

  logic signed [PHY_WIDTH:0] sh_x, sh_y;
  logic [1:0] sh_face, sh_pose, pose_in;
  logic       sh_valid;

  always_comb begin
    pose_in = 2'd0;
    case (char_state)
      4'd3:             pose_in = 2'd1;
      4'd4, 4'd5, 4'd6: pose_in = 2'd2;
      default:          pose_in = 2'd0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_face  <= 2'd0;
      sh_pose  <= 2'd0;
      sh_valid <= 1'b0;
    end else if (frame_start) begin
      sh_x     <= pos_x;
      sh_y     <= pos_y;
      sh_face  <= face;
      sh_pose  <= pose_in;
      sh_valid <= 1'b1;
    end
  end

  logic signed [11:0] x0, y0, dx, dy;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          in_box;

  // Offsets from the origin; a single signed range check per axis covers clipping.
  assign x0 = X_BASE - 12'(sh_x);
  assign y0 = Y_BASE - 12'(sh_y);
  assign dx = $signed({2'b00, h_cnt}) - x0;
  assign dy = $signed({2'b00, v_cnt}) - y0;
  assign in_box = sh_valid && (dx >= 12'sd0) && (dx < WX) && (dy >= 12'sd0) && (dy < WY);
  // Art faces left, so facing right mirrors the column.
  assign col = (sh_face == 2'b11) ? ~dx[CW-1:0] : dx[CW-1:0];
  assign row = dy[RW-1:0];

  logic in_box1, en1, in_box2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rom_addr     <= 12'd0;
      in_box1      <= 1'b0;
      en1          <= 1'b0;
      in_box2      <= 1'b0;
      pixel_out_en <= 1'b0;
    end else begin
      if (in_box) rom_addr <= {sh_pose, row, col};
      in_box1      <= in_box;
      en1          <= pixel_en;
      in_box2      <= in_box1;
      pixel_out_en <= en1;
    end
  end

  // ROM data arrives in the same cycle as the second pipeline stage.
  assign sprite_hit = in_box2 && pixel_out_en && (rom_data != TRANSPARENT);
  assign pixel_rgb  = sprite_hit ? rom_data[PIXEL_WIDTH-1:0] : '0;

endmodule
